mips_cpu_mem_arbiter: RTL and testbench



---
 rtl/mips_cpu_bus_pkg.sv | 26 ++
 rtl/mips_cpu_rr_pick.sv | 26 ++
 rtl/mips_cpu_mem_arbiter.sv | 111 +++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types, widths and helpers for the CPU memory bus arbiter.
package mips_cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

    localparam logic [BE_W-1:0] BE_WORD = {BE_W{1'b1}};

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic              read;
        logic              write;
    } bus_req_t;

    // Word-aligned bus address: byte offset bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(BE_W - 1);
    endfunction

endpackage

// File: rtl/mips_cpu_rr_pick.sv
// Two-port owner picker; last_grant state is held by the arbiter.
module mips_cpu_rr_pick
    import mips_cpu_bus_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    input  logic rr_enable,
    output logic owner_c
);

    always_comb begin
        owner_c = OWN_INSTR;
        if (i_req && d_req) begin
            // Round-robin hands contention to whoever lost last; fixed priority favours data.
            if (rr_enable && (last_grant == OWN_DATA)) begin
                owner_c = OWN_INSTR;
            end else begin
                owner_c = OWN_DATA;
            end
        end else if (d_req) begin
            owner_c = OWN_DATA;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares the single memory bus between instruction fetch and data ports,
// one latched access at a time with registered bus strobes and done pulses.
module mips_cpu_mem_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
);

    state_e   state;
    owner_e   last_grant;
    bus_req_t bus_q;
    bus_req_t grant_req;
    logic     d_req;
    logic     pick;

    assign d_req = d_read || d_write;

    mips_cpu_rr_pick u_pick (
        .i_req      (i_read),
        .d_req      (d_req),
        .last_grant (last_grant),
        .rr_enable  (RR_ENABLE),
        .owner_c    (pick)
    );

    // Bus fields the winning port would present if granted this cycle.
    always_comb begin
        grant_req = '0;
        if (pick == OWN_DATA) begin
            grant_req.address    = word_align(d_address);
            grant_req.writedata  = d_writedata;
            grant_req.byteenable = d_byteenable;
            grant_req.write      = d_write;
            grant_req.read       = !d_write;
        end else begin
            grant_req.address    = word_align(i_address);
            grant_req.byteenable = BE_WORD;
            grant_req.read       = 1'b1;
        end
    end

    // last_grant doubles as the owner of the in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= OWN_DATA;
            bus_q      <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_read || d_req) begin
                        last_grant <= owner_e'(pick);
                        bus_q      <= grant_req;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_waitrequest) begin
                        bus_q.read  <= 1'b0;
                        bus_q.write <= 1'b0;
                        i_done      <= (last_grant == OWN_INSTR);
                        d_done      <= (last_grant == OWN_DATA);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m_address    = bus_q.address;
    assign m_read       = bus_q.read;
    assign m_write      = bus_q.write;
    assign m_writedata  = bus_q.writedata;
    assign m_byteenable = bus_q.byteenable;

    // Read data passes straight through from the RAM during the done cycle.
    assign i_readdata = i_done ? m_readdata : '0;
    assign d_readdata = d_done ? m_readdata : '0;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter with a transaction-level reference model.
module tb_mips_cpu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_done;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_done;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] ram_q;
    logic        m_waitrequest;

    logic [31:0] fp_i_readdata, fp_d_readdata, fp_m_address, fp_m_writedata;
    logic        fp_i_done, fp_d_done, fp_m_read, fp_m_write;
    logic [3:0]  fp_m_byteenable;
    logic [31:0] fp_rdata;
    logic        fp_wait;

    int n_cmp = 0;
    int n_fail = 0;

    bit [31:0] ram  [256] = '{0: 32'h24020005, 1: 32'h8FBF0010, default: 32'h0};
    bit [31:0] gold [256] = '{0: 32'h24020005, 1: 32'h8FBF0010, default: 32'h0};

    mips_cpu_mem_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_done(i_done),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_done(d_done),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_readdata(ram_q), .m_waitrequest(m_waitrequest)
    );

    mips_cpu_mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(fp_i_readdata), .i_done(fp_i_done),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_readdata(fp_d_readdata), .d_done(fp_d_done),
        .m_address(fp_m_address), .m_read(fp_m_read), .m_write(fp_m_write),
        .m_writedata(fp_m_writedata), .m_byteenable(fp_m_byteenable),
        .m_readdata(fp_rdata), .m_waitrequest(fp_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Byte-enabled RAM with one-cycle registered reads, honouring waitrequest.
    always @(posedge clk) begin
        if (!m_waitrequest) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) ram[m_address[9:2]][8*b +: 8] = m_writedata[8*b +: 8];
            end
            if (m_read) ram_q <= ram[m_address[9:2]];
        end
    end

    // Owner choice straight from the arbitration rules; 1 = data port.
    function automatic bit model_pick(input bit ireq, input bit dreq, input bit last_d, input bit rr);
        if (ireq && dreq) return rr ? !last_d : 1'b1;
        return dreq;
    endfunction

    bit          p_strobe, p_wait, p_done, p_ireq, p_dreq, p_dwr;
    logic [31:0] p_iaddr, p_daddr, p_dwd;
    logic [3:0]  p_dbe;
    bit          m_last_d;
    bit          cur_d, cur_wr;
    logic [31:0] cur_addr, cur_wd;
    logic [3:0]  cur_be;

    // Per-cycle check of the RR instance against the transaction model.
    always @(negedge clk) begin
        bit exp_new, exp_strobe, exp_done;
        if (reset) begin
            chk("reset_quiet", 32'({m_read, m_write, i_done, d_done}), 32'h0);
            p_strobe = 1'b0;
            p_done   = 1'b0;
            p_wait   = 1'b0;
            p_ireq   = 1'b0;
            p_dreq   = 1'b0;
            m_last_d = 1'b1;
        end else begin
            exp_done   = p_strobe && !p_wait;
            exp_new    = !p_strobe && !p_done && (p_ireq || p_dreq);
            exp_strobe = exp_new || (p_strobe && p_wait);
            if (exp_new) begin
                cur_d    = model_pick(p_ireq, p_dreq, m_last_d, 1'b1);
                m_last_d = cur_d;
                if (cur_d) begin
                    cur_addr = {p_daddr[31:2], 2'b00};
                    cur_be   = p_dbe;
                    cur_wr   = p_dwr;
                    cur_wd   = p_dwd;
                end else begin
                    cur_addr = {p_iaddr[31:2], 2'b00};
                    cur_be   = 4'hF;
                    cur_wr   = 1'b0;
                    cur_wd   = 32'h0;
                end
            end
            chk("model_done", 32'({i_done, d_done}),
                exp_done ? (cur_d ? 32'h1 : 32'h2) : 32'h0);
            chk("model_strobe", 32'({m_read, m_write}),
                exp_strobe ? (cur_wr ? 32'h1 : 32'h2) : 32'h0);
            if (exp_strobe) begin
                chk("model_addr", m_address, cur_addr);
                chk("model_be", 32'(m_byteenable), 32'(cur_be));
                if (cur_wr) chk("model_wdata", m_writedata, cur_wd);
            end
            if (exp_done) begin
                if (cur_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (cur_be[b]) gold[cur_addr[9:2]][8*b +: 8] = cur_wd[8*b +: 8];
                end else begin
                    chk("model_rdata", cur_d ? d_readdata : i_readdata, gold[cur_addr[9:2]]);
                end
            end
            p_strobe = exp_strobe;
            p_done   = exp_done;
            p_wait   = m_waitrequest;
            p_ireq   = i_read;
            p_dreq   = d_read || d_write;
            p_dwr    = d_write;
            p_iaddr  = i_address;
            p_daddr  = d_address;
            p_dwd    = d_writedata;
            p_dbe    = d_byteenable;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One data access with zero waitrequest: strobe at N+1, done at N+2.
    task automatic data_txn(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] exp_addr, input logic [31:0] exp_strb,
                            output logic [31:0] rdv);
        cyc();
        d_read = rd; d_write = wr; d_address = a; d_writedata = wd; d_byteenable = be;
        smp();
        smp();
        chk({nm, "_strobe"}, 32'({m_read, m_write}), exp_strb);
        chk({nm, "_addr"}, m_address, exp_addr);
        chk({nm, "_be"}, 32'(m_byteenable), 32'(be));
        smp();
        chk({nm, "_done"}, 32'({i_done, d_done}), 32'h1);
        rdv = d_readdata;
        cyc();
        d_read = 1'b0; d_write = 1'b0;
    endtask

    bit [9:0]    ih, dh, fih, fdh;
    logic [31:0] rdv;

    initial begin
        reset = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_address = '0; d_writedata = '0; d_byteenable = '0; m_waitrequest = 1'b0;
        fp_rdata = '0; fp_wait = 1'b0; ram_q = '0;
        repeat (2) smp();
        chk("rst_m_address", m_address, 32'h0);
        chk("rst_m_be", 32'(m_byteenable), 32'h0);
        chk("rst_m_wdata", m_writedata, 32'h0);
        chk("rst_readdata", i_readdata | d_readdata, 32'h0);
        cyc();
        reset = 1'b0;

        // Fetch only
        cyc();
        i_read = 1'b1; i_address = 32'hBFC00000;
        smp();
        chk("fetch_n_idle", 32'(m_read), 32'h0);
        smp();
        chk("fetch_strobe", 32'({m_read, m_write}), 32'h2);
        chk("fetch_addr", m_address, 32'hBFC00000);
        chk("fetch_be", 32'(m_byteenable), 32'hF);
        smp();
        chk("fetch_done", 32'({i_done, d_done}), 32'h2);
        chk("fetch_rdata", i_readdata, 32'h24020005);
        cyc();
        i_read = 1'b0;
        cyc();

        // Store, zero-lane store, then load back
        data_txn("store", 1'b0, 1'b1, 32'h13, 32'hDEADBEEF, 4'b0011, 32'h10, 32'h1, rdv);
        chk("store_wdata_seen", gold[4], 32'h0000BEEF);
        data_txn("store_be0", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h10, 32'h1, rdv);
        data_txn("load", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h10, 32'h2, rdv);
        chk("load_lo", 32'(rdv[15:0]), 32'hBEEF);
        data_txn("rdwr", 1'b1, 1'b1, 32'h22, 32'h12345678, 4'hF, 32'h20, 32'h1, rdv);
        cyc();

        // Waitrequest held for three ISSUE cycles
        cyc();
        i_read = 1'b1; i_address = 32'hBFC00004; m_waitrequest = 1'b1;
        smp();
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk("wait_strobe", 32'({m_read, m_write}), 32'h2);
            chk("wait_addr", m_address, 32'hBFC00004);
            chk("wait_nodone", 32'({i_done, d_done}), 32'h0);
        end
        cyc();
        m_waitrequest = 1'b0;
        smp();
        chk("wait_strobe4", 32'(m_read), 32'h1);
        smp();
        chk("wait_done_n5", 32'(i_done), 32'h1);
        chk("wait_rdata", i_readdata, 32'h8FBF0010);
        cyc();
        i_read = 1'b0;
        cyc();

        // Contention from reset: RR instance and fixed-priority instance side by side
        cyc();
        reset = 1'b1;
        i_read = 1'b1; i_address = 32'hBFC00000;
        d_read = 1'b1; d_address = 32'h10; d_byteenable = 4'hF;
        smp();
        cyc();
        reset = 1'b0;
        smp();
        ih = '0; dh = '0; fih = '0; fdh = '0;
        for (int k = 1; k <= 9; k++) begin
            smp();
            ih[k] = i_done; dh[k] = d_done; fih[k] = fp_i_done; fdh[k] = fp_d_done;
        end
        chk("rr_i_done_cycles", 32'(ih), 32'h104);
        chk("rr_d_done_cycles", 32'(dh), 32'h020);
        chk("fp_i_done_cycles", 32'(fih), 32'h000);
        chk("fp_d_done_cycles", 32'(fdh), 32'h124);
        cyc();
        i_read = 1'b0; d_read = 1'b0;
        repeat (4) cyc();

        // Reset asserted mid-ISSUE
        i_read = 1'b1; i_address = 32'hBFC00000;
        smp();
        cyc();
        #1;
        chk("rst_mid_pre", 32'(m_read), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_strobe", 32'({m_read, m_write}), 32'h0);
        smp();
        chk("rst_mid_nodone", 32'({i_done, d_done}), 32'h0);
        cyc();
        reset = 1'b0;
        smp();
        smp();
        chk("rst_refetch_strobe", 32'(m_read), 32'h1);
        smp();
        chk("rst_refetch_done", 32'(i_done), 32'h1);
        chk("rst_refetch_rdata", i_readdata, 32'h24020005);
        cyc();
        i_read = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
